// File: rtl/row_wr_buff.sv
// row_wr_buff: 8x8 bit array with bit, byte, clear-row and clear-all writes. Optional ROW_WR_PARITY_EN adds per-row parity.
// Latency: data updates 1 cycle after acceptance; clear-all takes 8 cycles. done/err are registered pulses.
// Backpressure: req_ready is high only in IDLE. req_valid while busy is ignored, not queued.
module row_wr_buff #(
  parameter logic [63:0] INIT_VAL = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  row,
  input  logic [7:0]  col,
  input  logic [1:0]  mode,
  input  logic        wr_bit,
  input  logic [7:0]  wr_byte,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [63:0] data,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef ROW_WR_PARITY_EN
  ,
  output logic [7:0]  row_par
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, CLR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  row_q, col_q, wr_byte_q;
  logic [1:0]  mode_q;
  logic        wr_bit_q;
  logic [2:0]  cnt, cnt_nxt;
  logic [63:0] data_nxt;
  logic        done_nxt, err_nxt;
  logic        accept;
  logic        rejected;
  logic [2:0]  r_idx, c_idx;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] oh_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef ROW_WR_PARITY_EN
  function automatic logic [7:0] row_parity(input logic [63:0] d);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign r_idx     = oh_idx(row_q);
  assign c_idx     = oh_idx(col_q);
  // Clear-all never reaches WRITE, so its mode value needs no exemption here.
  assign rejected  = !is_onehot(row_q) || ((mode_q == 2'b00) && !is_onehot(col_q));

  // State register; reset also wins over a same-edge request.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and next array contents.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = (mode == 2'b11) ? CLR : WRITE;
          cnt_nxt   = 3'd0;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        err_nxt   = rejected;
        if (!rejected) begin
          case (mode_q)
            2'b00:   data_nxt[{r_idx, c_idx}]       = wr_bit_q;
            2'b01:   data_nxt[{r_idx, 3'b000} +: 8] = wr_byte_q;
            2'b10:   data_nxt[{r_idx, 3'b000} +: 8] = 8'h00;
            default: ;
          endcase
        end
      end
      CLR: begin
        data_nxt[{cnt, 3'b000} +: 8] = 8'h00;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are held for the WRITE cycle; they need no reset value.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      row_q     <= row;
      col_q     <= col;
      mode_q    <= mode;
      wr_bit_q  <= wr_bit;
      wr_byte_q <= wr_byte;
    end
  end

  // Array, clear counter and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= INIT_VAL;
      cnt  <= 3'd0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      data <= data_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
      err  <= err_nxt;
    end
  end

`ifdef ROW_WR_PARITY_EN
  // Parity tracks the array on the same edge, computed from its next value.
  always_ff @(posedge clk) begin
    if (rst) row_par <= row_parity(INIT_VAL);
    else     row_par <= row_parity(data_nxt);
  end
`endif

endmodule

// File: doc/row_wr_buff.md
ROW_WR_BUFF -- requirements
Module: row_wr_buff

Interface
REQ-001 Parameter INIT_VAL, default 64'h0, value loaded into data on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 row  input  8  one-hot row select; bit k selects data[8k+7:8k].
REQ-005 col  input  8  one-hot column select within the row; bit j selects byte bit j.
REQ-006 mode  input  2  00 bit write, 01 byte write, 10 clear row, 11 clear all.
REQ-007 wr_bit  input  1  value written in bit mode.
REQ-008 wr_byte  input  8  value written in byte mode.
REQ-009 req_valid  input  1  request present; row/col/mode/wr_* stable while asserted.
REQ-010 req_ready  output  1  block can accept a request.
REQ-011 data  output  64  registered 8x8 bit array.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse on request completion.
REQ-014 err  output  1  one-cycle pulse, coincident with done, on rejected addressing.
REQ-015 row_par  output  8  per-row even parity; present only with ROW_WR_PARITY_EN.

Function
REQ-016 FSM states: IDLE, WRITE, CLR; req_ready SHALL be 1 only in IDLE.
REQ-017 Handshake: request accepted on the edge where req_valid & req_ready; row, col, mode, wr_bit, wr_byte captured into registers on that edge.
REQ-018 IDLE -> WRITE on acceptance with mode 00/01/10; IDLE -> CLR on acceptance with mode 11, row counter cleared to 0.
REQ-019 WRITE: data updated on the next edge, done=1 for the following cycle, return to IDLE; latency acceptance-to-data 1 cycle, throughput 1 request per 2 cycles.
REQ-020 Bit mode: only data[8k+j] changes to wr_bit; all other 63 bits hold.
REQ-021 Byte mode: data[8k+7:8k] <= wr_byte; col ignored.
REQ-022 Clear row: data[8k+7:8k] <= 0; col ignored.
REQ-023 CLR: one row cleared per cycle, row 0 to row 7, counter 3 bits; after the row-7 edge, done pulses and state returns to IDLE (8 cycles busy); row/col ignored.
REQ-024 Rejection: row not exactly one-hot (modes 00/01/10), or col not exactly one-hot (mode 00) -> request accepted, data unchanged, done and err pulse together after the WRITE cycle.
REQ-025 req_valid while busy SHALL be ignored (not accepted, not queued).
REQ-026 done and err SHALL be 0 in every cycle not specified above.

Reset
REQ-027 rst on a clock edge: data <= INIT_VAL, state <= IDLE, counter <= 0, done <= 0, err <= 0, row_par <= parity of INIT_VAL.
REQ-028 rst overrides any request on the same edge; the request is not accepted.
REQ-029 rst during WRITE or CLR aborts the operation: no done, no err, partial clears discarded by the INIT_VAL load.

Configuration
REQ-030 Macro ROW_WR_PARITY_EN defined: row_par[k] = XOR of data[8k+7:8k], registered, updated on the same edge as data.
REQ-031 Macro ROW_WR_PARITY_EN undefined: row_par port and logic absent; all other behaviour identical.

Verification
REQ-032 Reset with INIT_VAL=0, then bit write row=8'h04 col=8'h10 wr_bit=1 -> data=64'h0000_0000_0010_0000 one cycle after acceptance, done pulse, err=0.
REQ-033 Byte write row=8'h80 wr_byte=8'hA5 col=8'h00 -> data[63:56]=8'hA5, other bytes unchanged, err=0.
REQ-034 data=64'hFFFF_FFFF_FFFF_FFFF, mode 11 -> busy 8 cycles, data=0 after the row-7 edge, single done pulse, req_valid ignored during busy.
REQ-035 Bit write row=8'h03 col=8'h01 -> data unchanged, done=1 and err=1 in the same cycle.
REQ-036 Reset asserted on the 4th cycle of CLR -> data=INIT_VAL, state IDLE, req_ready=1 next cycle, no done.
REQ-037 With ROW_WR_PARITY_EN, byte write row=8'h01 wr_byte=8'h07 -> row_par[0]=1 on the same edge data updates.
